// File: rtl/alu_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_if
// Bundles the button, switch-bus, ALU and display signals of the ALU operand
// sequencer.
//   master : board/ALU side - drives load_btn, clear_btn, dato, alu_result;
//            observes alu_a, alu_b, alu_op, result, result_valid, state
//   slave  : the sequencer itself (directions mirrored)
// Parameters: DATA_W (operand/bus/result width), OP_W (opcode width).
// ---------------------------------------------------------------------------
interface alu_operand_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic              load_btn;
    logic              clear_btn;
    logic [DATA_W-1:0] dato;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [2:0]        state;

    modport master (
        output load_btn, clear_btn, dato, alu_result,
        input  alu_a, alu_b, alu_op, result, result_valid, state
    );

    modport slave (
        input  load_btn, clear_btn, dato, alu_result,
        output alu_a, alu_b, alu_op, result, result_valid, state
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
// Step-button driven front end for the board ALU. Successive presses capture
// operand A, operand B and the opcode from the switch bus; the cycle after the
// opcode capture the ALU result is latched and flagged valid, and held until
// the next press (which starts a new operation with a fresh operand A) or a
// clear.
//
// Ports:
//   clk    - system clock, all registers update on the rising edge
//   reset  - synchronous, active-high; zeroes every output and the history
//   bus    - alu_operand_sequencer_if.slave:
//              load_btn, clear_btn, dato, alu_result (in)
//              alu_a, alu_b, alu_op, result, result_valid, state (out)
//
// Build option: define ALU_SEQ_DEBOUNCE_EN to qualify load_btn with a
// DEBOUNCE_CYCLES-sample stability counter. Without it load_btn is used as is
// and no counter exists. clear_btn is never debounced.
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int DATA_W          = 8,
    parameter int OP_W            = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_operand_sequencer_if.slave bus
);
    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [OP_W-1:0]   alu_op_r;
    logic [DATA_W-1:0] result_r;
    logic              valid_r;
    logic [2:0]        state_r;

    logic qual;   // qualified button level
    logic btn_q;  // qualified level from the previous cycle
    logic press;

`ifdef ALU_SEQ_DEBOUNCE_EN
    // Counts consecutive high samples, saturating at DEBOUNCE_CYCLES-1 so the
    // current high sample completes the run; any low sample restarts it.
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (reset || !bus.load_btn) begin
            db_cnt <= '0;
        end else if (db_cnt != CNT_MAX) begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    assign qual = bus.load_btn && (db_cnt == CNT_MAX);
`else
    assign qual = bus.load_btn;

    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES > 0);
`endif

    // One press per rising edge of the qualified level, however long it is held.
    assign press = qual && !btn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= qual;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear_btn) begin
            // Clear outranks a simultaneous press: nothing is captured.
            state_r  <= S_A;
            alu_a_r  <= '0;
            alu_b_r  <= '0;
            alu_op_r <= '0;
            result_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            case (state_r)
                S_A: begin
                    if (press) begin
                        alu_a_r <= bus.dato;
                        state_r <= S_B;
                    end
                end
                S_B: begin
                    if (press) begin
                        alu_b_r <= bus.dato;
                        state_r <= S_OP;
                    end
                end
                S_OP: begin
                    if (press) begin
                        alu_op_r <= bus.dato[OP_W-1:0];
                        state_r  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for a full cycle; sample the
                    // ALU now. A press arriving here is dropped.
                    result_r <= bus.alu_result;
                    valid_r  <= 1'b1;
                    state_r  <= S_SHOW;
                end
                S_SHOW: begin
                    // A press here is the A capture of the next operation;
                    // the old result stays visible but is no longer valid.
                    if (press) begin
                        alu_a_r <= bus.dato;
                        valid_r <= 1'b0;
                        state_r <= S_B;
                    end
                end
                default: begin
                    state_r <= S_A;
                end
            endcase
        end
    end

    assign bus.alu_a        = alu_a_r;
    assign bus.alu_b        = alu_b_r;
    assign bus.alu_op       = alu_op_r;
    assign bus.result       = result_r;
    assign bus.result_valid = valid_r;
    assign bus.state        = state_r;
endmodule
